find_first_one_seq: RTL and testbench

- Multi-cycle bit scanner for the ALU datapath. Reports the position of the lowest set bit of a latched operand, or that the operand is all zero.
- Serves as the positional counterpart of the ALU zero-detect flag: zero-detect says whether any bit is set, this block says which bit is the first one set.
- Used for the count-trailing-zeros and bit-search paths of the multi-cycle execute stage.
- Examines STEP bits per clock, LSB first, and stops early on the first hit.

---
 rtl/find_first_one_seq.sv | 111 +++++++++++
 tb/tb_find_first_one_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/find_first_one_seq.sv
// Multi-cycle lowest-set-bit scanner: examines STEP bits per cycle, LSB first, stopping on the first hit.
// Optional FFO_FAST_ZERO_EN: an all-zero operand skips SCAN and completes in the acceptance cycle.
module find_first_one_seq #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic [IDX_W-1:0] index
);

   localparam int NCH      = WIDTH / STEP;
   localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int LOG_STEP = $clog2(STEP);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [CW-1:0]    chunk_q, chunk_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic             zero_q, zero_d;

   logic [IDX_W-1:0] base;
   logic [STEP-1:0]  slice;
   logic [IDX_W-1:0] hit_j;
   logic             hit;
   logic             last_chunk;

   // Current slice and the lowest set bit inside it.
   always_comb begin
      base  = IDX_W'(chunk_q) << LOG_STEP;
      slice = STEP'(opnd_q >> base);
      hit   = |slice;
      hit_j = '0;
      for (int j = STEP - 1; j >= 0; j--) begin
         if (slice[j]) hit_j = IDX_W'(j);
      end
      last_chunk = (chunk_q == CW'(NCH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         opnd_q  <= '0;
         chunk_q <= '0;
         index_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         chunk_q <= chunk_d;
         index_q <= index_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      chunk_d = chunk_q;
      index_d = index_q;
      zero_d  = zero_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               opnd_d  = data_in;
               chunk_d = '0;
`ifdef FFO_FAST_ZERO_EN
               if (~|data_in) begin
                  state_d = DONE;
                  zero_d  = 1'b1;
                  index_d = '0;
               end else begin
                  state_d = SCAN;
               end
`else
               state_d = SCAN;
`endif
            end
         end
         SCAN: begin
            if (hit) begin
               index_d = base + hit_j;
               zero_d  = 1'b0;
               state_d = DONE;
            end else if (last_chunk) begin
               index_d = '0;
               zero_d  = 1'b1;
               state_d = DONE;
            end else begin
               chunk_d = chunk_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign zero  = zero_q;
   assign index = index_q;

endmodule

// File: tb/tb_find_first_one_seq.sv
// Directed plus randomized bench for find_first_one_seq; a trailing-zero-count model gives index and latency.
module tb_find_first_one_seq;

   localparam int WIDTH = 32;
   localparam int STEP  = 4;
   localparam int IDX_W = 5;
   localparam int NCH   = WIDTH / STEP;
`ifdef FFO_FAST_ZERO_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             busy, done, zero;
   logic [IDX_W-1:0] index;

   int tests = 0;
   int fails = 0;

   find_first_one_seq #(.WIDTH(WIDTH), .STEP(STEP), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in),
      .busy(busy), .done(done), .zero(zero), .index(index)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: lowest set bit by linear search; cycles from acceptance edge to done cycle.
   task automatic model(input logic [WIDTH-1:0] d, output int idx, output bit z, output int lat);
      idx = 0;
      z   = 1'b1;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (d[i]) begin
            idx = i;
            z   = 1'b0;
         end
      end
      if (z) lat = FAST ? 0 : NCH;
      else   lat = idx / STEP + 1;
   endtask

   // Called at #1 after an edge with the DUT idle. Random start/data_in noise while busy must be ignored.
   task automatic run_op(input logic [WIDTH-1:0] d, input string tag);
      int  eidx, lat;
      bit  ez;
      model(d, eidx, ez, lat);
      start   = 1'b1;
      data_in = d;
      @(posedge clk); #1;
      for (int k = 0; k <= lat; k++) begin
         check({tag, ".busy"}, 32'(busy), 32'd1);
         check({tag, ".done"}, 32'(done), 32'(k == lat));
         if (k == lat) begin
            check({tag, ".index"}, 32'(index), 32'(eidx));
            check({tag, ".zero"},  32'(zero),  32'(ez));
         end
         start   = 1'($urandom_range(0, 1));
         data_in = $urandom;
         @(posedge clk); #1;
      end
      check({tag, ".idle_busy"},  32'(busy),  32'd0);
      check({tag, ".idle_done"},  32'(done),  32'd0);
      check({tag, ".hold_index"}, 32'(index), 32'(eidx));
      check({tag, ".hold_zero"},  32'(zero),  32'(ez));
      start = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] d;
      int sh;
      rst = 1'b1; start = 1'b0; data_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst.busy",  32'(busy),  32'd0);
      check("rst.done",  32'(done),  32'd0);
      check("rst.zero",  32'(zero),  32'd0);
      check("rst.index", 32'(index), 32'd0);

      run_op(32'h0000_0001, "bit0");
      run_op(32'h8000_0000, "bit31");
      run_op(32'h00F0_0010, "bit4");
      run_op(32'h0000_0000, "allzero");
      run_op(32'h0001_0000, "bit16");
      run_op(32'h0000_0000, "allzero2");

      // Reset in the middle of a scan drops the request.
      start = 1'b1; data_in = 32'h4000_0000;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst.busy",  32'(busy),  32'd0);
      check("midrst.done",  32'(done),  32'd0);
      check("midrst.zero",  32'(zero),  32'd0);
      check("midrst.index", 32'(index), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("midrst.nodone", 32'(done | busy), 32'd0);
      end
      run_op(32'h0000_0100, "restart");

      // Start held high: one accept per done + idle cycle.
      start = 1'b1; data_in = 32'h0000_0002;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         check("b2b.done", 32'(done), 32'((k % 3) == 1));
         if ((k % 3) == 1) check("b2b.index", 32'(index), 32'd1);
      end
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("b2b.idle", 32'(busy), 32'd0);

      for (int n = 0; n < 40; n++) begin
         sh = $urandom_range(0, 32);
         d  = (sh == 32) ? '0 : (($urandom | 32'd1) << sh);
         run_op(d, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
